// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with two read ports, one write port and a write scoreboard
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     busy_cnt_q, busy_cnt_d;
  logic                wr_ok, retire;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_ok     = wr_en && !is_zero(wr_addr);
  assign retire    = wr_ok && busy_q[wr_addr];
  assign iss_ready = iss_en && !busy_q[iss_addr] && !is_zero(iss_addr);
  assign busy_cnt  = busy_cnt_q;

  // Issue is applied after the write clear so a same-cycle issue to the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)     busy_d[wr_addr]  = 1'b0;
    if (iss_ready) busy_d[iss_addr] = 1'b1;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (iss_ready && !retire)      busy_cnt_d = busy_cnt_q + (ADDR_W+1)'(1);
    else if (retire && !iss_ready) busy_cnt_d = busy_cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rs_data = is_zero(rs) ? '0 : regs_q[rs];
    rt_data = is_zero(rt) ? '0 : regs_q[rt];
    rs_busy = busy_q[rs] && !is_zero(rs);
    rt_busy = busy_q[rt] && !is_zero(rt);
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_ok && (rs == wr_addr)) begin
      rs_data = wr_data;
      rs_busy = 1'b0;
    end
    if (wr_ok && (rt == wr_addr)) begin
      rt_data = wr_data;
      rt_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs, rt, wr_addr, iss_addr;
  logic [DW-1:0] rs_data, rt_data, wr_data;
  logic          rs_busy, rt_busy, wr_en, iss_en, iss_ready;
  logic [AW:0]   busy_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready), .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] rd;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
    int            exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && idx == wr_addr) return wr_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic exp_bz(input logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && idx == wr_addr) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  function automatic logic exp_ready();
    return iss_en && iss_addr != 0 && !m_busy[iss_addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_comb(input string tag);
    chk({tag, ".rs_data"}, rs_data, exp_rd(rs));
    chk({tag, ".rt_data"}, rt_data, exp_rd(rt));
    chk({tag, ".rs_busy"}, rs_busy, exp_bz(rs));
    chk({tag, ".rt_busy"}, rt_busy, exp_bz(rt));
    chk({tag, ".iss_ready"}, iss_ready, exp_ready());
    chk({tag, ".busy_cnt"}, busy_cnt, m_cnt());
  endtask

  // Advance one clock and apply the architectural effect of the inputs to the model.
  task automatic tick();
    logic          acc, w;
    logic [AW-1:0] wa, ia;
    logic [DW-1:0] wd;
    acc = exp_ready();
    w = wr_en && wr_addr != 0;
    wa = wr_addr; wd = wr_data; ia = iss_addr;
    @(posedge clk);
    #1;
    if (w) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (acc) m_busy[ia] = 1'b1;
  endtask

  vec_t vecs [9];

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; iss_addr = 0; rs = 0; rt = 0;
    model_reset();
    #12 rst_n = 1'b1;
    #1 check_comb("reset");

    //         wr  wa  wdata         iss ia  rd  rdy data          bz cnt
    vecs[0] = '{1, 5, 32'h12345678, 0, 0, 5, 0, 32'h12345678, 0, 0};
    vecs[1] = '{0, 0, 32'h0,        1, 7, 7, 1, 32'h0,        1, 1};
    vecs[2] = '{0, 0, 32'h0,        1, 7, 7, 0, 32'h0,        1, 1};
    vecs[3] = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 0, 32'hA5A5A5A5, 0, 0};
    vecs[4] = '{1, 3, 32'h55,       1, 3, 3, 1, 32'h55,       1, 1};
    vecs[5] = '{1, 3, 32'h66,       1, 4, 3, 1, 32'h66,       0, 1};
    vecs[6] = '{0, 0, 32'h0,        1, 0, 4, 0, 32'h0,        1, 1};
    vecs[7] = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 1};
    vecs[8] = '{1, 4, 32'h1,        0, 0, 4, 0, 32'h1,        0, 0};

    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
      rs = vecs[i].rd; rt = vecs[i].rd;
      #1 chk($sformatf("vec%0d.iss_ready", i), iss_ready, vecs[i].exp_ready);
      tick();
      wr_en = 0; iss_en = 0;
      #1;
      chk($sformatf("vec%0d.rs_data", i), rs_data, vecs[i].exp_data);
      chk($sformatf("vec%0d.rt_data", i), rt_data, vecs[i].exp_data);
      chk($sformatf("vec%0d.rs_busy", i), rs_busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d.busy_cnt", i), busy_cnt, vecs[i].exp_cnt);
    end

    // Same-cycle read of a register being written while it is busy.
    iss_en = 1; iss_addr = 9;
    tick();
    iss_en = 0;
    wr_en = 1; wr_addr = 9; wr_data = 32'hCAFEF00D; rs = 9; rt = 9;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("same_cycle.rs_data", rs_data, 32'hCAFEF00D);
    chk("same_cycle.rs_busy", rs_busy, 1'b0);
`else
    chk("same_cycle.rs_data", rs_data, 32'h0);
    chk("same_cycle.rs_busy", rs_busy, 1'b1);
`endif
    check_comb("same_cycle");
    tick();
    wr_en = 0;
    #1;
    chk("after_wr.rs_data", rs_data, 32'hCAFEF00D);
    chk("after_wr.busy_cnt", busy_cnt, 0);

    // Fill every trackable register, then retire them all.
    for (int a = 1; a < NR; a++) begin
      iss_en = 1; iss_addr = AW'(a);
      #1 chk($sformatf("fill%0d.iss_ready", a), iss_ready, 1'b1);
      tick();
    end
    iss_en = 0;
    #1 chk("fill.busy_cnt", busy_cnt, 31);
    iss_en = 1; iss_addr = 1;
    #1 chk("fill.reissue_ready", iss_ready, 1'b0);
    iss_en = 0;
    for (int a = 1; a < NR; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = DW'(a * 3);
      tick();
    end
    wr_en = 0;
    #1 chk("drain.busy_cnt", busy_cnt, 0);

    // Randomized traffic against the model, addresses confined to force collisions.
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 7)); wr_data = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_addr = AW'($urandom_range(0, 7));
      rs = AW'($urandom_range(0, 7)); rt = AW'($urandom_range(0, 7));
      #1 check_comb($sformatf("rand%0d", i));
      tick();
    end

    // Asynchronous reset mid-operation with pending writes outstanding.
    wr_en = 0; iss_en = 1; iss_addr = 12;
    tick();
    iss_addr = 13;
    tick();
    iss_en = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.busy_cnt", busy_cnt, 0);
    iss_en = 1; iss_addr = 0;
    #1 chk("mid_rst.iss_ready_r0", iss_ready, 1'b0);
    iss_en = 0;
    for (int i = 0; i < NR; i++) begin
      rs = AW'(i); rt = AW'(NR - 1 - i);
      #1;
      chk($sformatf("mid_rst.rs%0d", i), rs_data, 32'h0);
      chk($sformatf("mid_rst.rt%0d", i), rt_data, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; rs = 0; rt = 0;
    #1 chk("r0_wr.same_cycle", rs_data, 32'h0);
    tick();
    wr_en = 0;
    #1;
    chk("r0_wr.rs_data", rs_data, 32'h0);
    chk("r0_wr.rs_busy", rs_busy, 1'b0);
    check_comb("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated write scoreboard. It is the successor to the single-write, unreset integer/float register files, and one instance serves either the integer or the float datapath. The block provides two combinational read ports and one write port. It tracks per-register "pending write" bits for multi-cycle units, so decode can detect RAW/WAW hazards and stall.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rs  in  ADDR_W  read port A index
- rt  in  ADDR_W  read port B index
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- rs_busy  out  1  register rs has a pending write
- rt_busy  out  1  register rt has a pending write
- wr_en  in  1  write strobe; also retires any pending write to wr_addr
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- iss_en  in  1  request to mark iss_addr as pending
- iss_addr  in  ADDR_W  destination being issued
- iss_ready  out  1  issue accepted this cycle
- busy_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- State consists of NUM_REGS x DATA_W data flops, the busy[NUM_REGS] vector and the busy_cnt counter.
- Reset (rst_n low, asynchronous):
  - all registers are 0, all busy bits are 0, busy_cnt is 0.
  - Reset asserted mid-operation discards pending writes and in-flight issues immediately.
- Write: on a clock edge with wr_en high, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - A write to an untracked (not busy) register is legal.
- Issue:
  - iss_ready = iss_en & !busy[iss_addr] & !(ZERO_REG & iss_addr==0). It is combinational with no lookahead, so WAW is blocked until retirement.
  - On an edge with iss_ready high, busy[iss_addr] <= 1.
- Simultaneous iss and wr to the same non-busy register in one cycle:
  - data is written and busy ends at 1 (issue wins).
  - busy_cnt increments by 1.
- busy_cnt update per edge:
  - +1 on an accepted issue.
  - -1 on a wr_en that clears a set busy bit.
  - net 0 when both happen in the same cycle.
  - Never wraps: the maximum is NUM_REGS (or NUM_REGS-1 with ZERO_REG).
- Zero register (ZERO_REG=1): reads of index 0 return 0 and busy 0; writes to index 0 are dropped; issues to index 0 give iss_ready=0.
- Reads with rs==rt are legal and return identical data.

## Timing
- Read latency is 0 cycles. rs_data, rs_busy, rt_data and rt_busy are combinational from the index and the current state.
- Write-to-read latency is 1 cycle without bypass; data is visible after the edge.
- Issue-to-busy latency: busy is visible on rs_busy/rt_busy in the cycle after the accepting edge.
- iss_ready is valid in the same cycle as iss_en.
- The requester holds iss_en and iss_addr until iss_ready is high.
- No other handshake exists; wr_en is always accepted.

## Configuration
- REG_FILE_SB_BYPASS_EN defined:
  - a read port whose index equals wr_addr while wr_en is high (and the index is not the zero register) returns wr_data combinationally, with its busy output forced to 0.
  - Bypass applies to port A and port B independently.
- REG_FILE_SB_BYPASS_EN undefined:
  - reads return the stored value and the stored busy bit.
  - The consumer must wait one cycle after the write.

## Test plan
- Reset and zero register: with rst_n pulsed low mid-run, all reads return 0, busy_cnt is 0 and iss_ready is 0 for iss_addr=0. Then wr_en to r0 with 0xDEADBEEF still reads 0.
- Basic write/read: wr r5 = 0x12345678, then the next cycle rs=5, rt=5 gives both ports 0x12345678.
  - With bypass: same-cycle read also returns 0x12345678.
  - Without bypass: same-cycle read returns the old value 0.
- Scoreboard: issue r7 gives rs_busy=1 and busy_cnt=1 the next cycle.
  - A second issue to r7 gives iss_ready=0.
  - wr r7 = 0xA5A5A5A5 clears busy, gives busy_cnt=0, and r7 reads 0xA5A5A5A5.
- Simultaneous events: in one cycle, issue r3 (not busy) and wr r3 = 0x55. The next cycle shows busy[3]=1, data 0x55, busy_cnt=1.
  - Issue r4 together with retiring a busy r3 leaves busy_cnt unchanged.
- Fill: issue all registers 1..31 back-to-back; busy_cnt reaches 31 with no wrap. Retire all of them and busy_cnt returns to 0.
